alu_imm_iq: RTL and testbench
=============================

// Module: alu_imm_iq
// PURPOSE
//  Issue queue and scheduler for ALU reg-imm ops. Accepts in-order enqueues from the ALU reg-imm
//  dispatch queue. Tracks operand A readiness via writeback-bus wakeup. Each cycle, issues the
//  oldest ready op to the ALU reg-imm pipeline, with a PRF read request or a forward indication.
//  Age-ordered collapsing queue: entry 0 is always the oldest.
// PARAMETERS
//  ALU_IMM_IQ_ENTRIES  8  number of queue entries, >=2; LOG_PR_COUNT/LOG_ROB_ENTRIES/PRF_BANK_COUNT from core_types_pkg
// PORTS
//  CLK                      in   1                                 clock
//  nRST                     in   1                                 reset, synchronous, active-low
//  iq_enq_valid             in   1                                 enqueue request from dispatch queue
//  iq_enq_op                in   4                                 ALU op
//  iq_enq_imm12             in   12                                immediate
//  iq_enq_A_PR              in   LOG_PR_COUNT                      operand A physical reg
//  iq_enq_A_ready           in   1                                 A already written
//  iq_enq_A_is_zero         in   1                                 A is x0 (needs no PRF read)
//  iq_enq_dest_PR           in   LOG_PR_COUNT                      destination PR
//  iq_enq_ROB_index         in   LOG_ROB_ENTRIES                   ROB index
//  iq_enq_ready             out  1                                 queue can accept an enqueue
//  WB_bus_valid_by_bank     in   PRF_BANK_COUNT                    writeback valid per PRF bank
//  WB_bus_upper_PR_by_bank  in   PRF_BANK_COUNT x (LOG_PR_COUNT-LOG_PRF_BANK_COUNT)  upper PR bits per bank
//  issue_valid              out  1                                 op issued this cycle
//  issue_op / issue_imm12 / issue_A_is_zero / issue_dest_PR / issue_ROB_index  out  as enq  issued op fields
//  issue_A_forward          out  1                                 A must come from this cycle's WB bus
//  issue_A_bank             out  LOG_PRF_BANK_COUNT                bank of A (A_PR low bits)
//  prf_req_A_valid          out  1                                 PRF read request for A
//  prf_req_A_PR             out  LOG_PR_COUNT                      PR to read
//  issue_ready              in   1                                 pipeline can accept an op this cycle
// BEHAVIOUR
//  - Wakeup: new_ready[i] = WB_bus_valid_by_bank[bank(A_PR[i])] & (WB_bus_upper_PR_by_bank[bank] == A_PR[i] upper bits).
//    ready[i] = valid[i] & (A_ready[i] | A_is_zero[i] | new_ready[i]).
//  - Select: sel = lowest-index i with ready[i]. issue_valid = (|ready) & issue_ready. An op leaves the queue iff issue_valid.
//  - Issue fields: one-hot mux of entry sel. issue_A_forward = new_ready[sel] & ~A_ready[sel] & ~A_is_zero[sel].
//    prf_req_A_valid = issue_valid & ~A_is_zero[sel] & ~issue_A_forward. prf_req_A_PR = A_PR[sel].
//  - Outputs are combinational from registered state + WB bus + issue_ready. All data outputs are 0 when no entry is ready.
//  - Issued entry is removed. Entries above sel shift down by one in the same edge; entries below hold.
//    Shifted and held entries latch A_ready |= new_ready.
//  - iq_enq_ready = ~valid[ENTRIES-1]. This is conservative: a same-cycle issue does not free space for that cycle's enqueue.
//  - Enqueue accepted iff iq_enq_valid & iq_enq_ready. The op is written to the lowest invalid slot after collapse:
//    slot = popcount(valid) - issue_valid.
//    Stored A_ready = iq_enq_A_ready | wakeup match on the same cycle's WB bus.
//    A newly enqueued op cannot issue before the next cycle (latency enq->issue >= 1).
//  - Full: no enqueue accepted, issue continues. Empty: issue_valid=0, prf_req_A_valid=0.
//  - Simultaneous issue + enqueue at full-1 or full is legal; the queue ordering invariant is preserved.
//  - issue_ready=0: no state change except wakeup latching and enqueue.
//  - Reset (including mid-operation): all valid=0 and all entry fields=0 on the next edge.
//    Resulting outputs: iq_enq_ready=1, issue_valid=0, prf_req_A_valid=0, all data outputs 0.
// TESTING
//  - Reset then enqueue op=4'h3, imm=12'h7FF, A_ready=1, dest=PR 9, issue_ready=1.
//    -> next cycle issue_valid=1, prf_req_A_PR=A_PR, forward=0.
//  - Enqueue A(A_ready=0, A_PR=12) then B(A_ready=1).
//    -> B issues first; later WB bus bank(12) matches upper(12).
//    -> A issues that same cycle with issue_A_forward=1, prf_req_A_valid=0.
//  - Fill 8 entries, all with A_ready=0 -> iq_enq_ready=0, no issue. Wake entry 5 -> entry 5 issues.
//    -> entries 6,7 shift to 5,6 with order kept; iq_enq_ready=1 the next cycle.
//  - Simultaneous issue of entry 0 and enqueue with 3 valid -> new op lands in slot 2, ages intact.
//  - Enqueue with A_is_zero=1, A_ready=0 -> issues next cycle, prf_req_A_valid=0, forward=0.
//  - issue_ready=0 for 3 cycles with 2 ready entries -> no issue, no loss.
//    Assert nRST=0 mid-stream -> queue empty and outputs 0 the next cycle.

Source files
------------

// File: rtl/alu_imm_iq.sv
// alu_imm_iq: age-ordered collapsing issue queue for ALU reg-imm ops.
// Entry 0 is always the oldest op. Operand A wakes up from the writeback bus.
// Each cycle the oldest ready op is issued, either with a PRF read request for A
// or with a flag saying that A must be taken from this cycle's writeback bus.
module alu_imm_iq #(
    parameter int ALU_IMM_IQ_ENTRIES = 8,
    parameter int LOG_PR_COUNT       = 7,
    parameter int LOG_ROB_ENTRIES    = 7,
    parameter int LOG_PRF_BANK_COUNT = 2,
    parameter int PRF_BANK_COUNT     = 1 << LOG_PRF_BANK_COUNT
) (
    input  logic                                  CLK,
    input  logic                                  nRST,
    // enqueue from the dispatch queue
    input  logic                                  iq_enq_valid,
    input  logic [3:0]                            iq_enq_op,
    input  logic [11:0]                           iq_enq_imm12,
    input  logic [LOG_PR_COUNT-1:0]               iq_enq_A_PR,
    input  logic                                  iq_enq_A_ready,
    input  logic                                  iq_enq_A_is_zero,
    input  logic [LOG_PR_COUNT-1:0]               iq_enq_dest_PR,
    input  logic [LOG_ROB_ENTRIES-1:0]            iq_enq_ROB_index,
    output logic                                  iq_enq_ready,
    // writeback bus used for wakeup
    input  logic [PRF_BANK_COUNT-1:0]             WB_bus_valid_by_bank,
    input  logic [PRF_BANK_COUNT-1:0][LOG_PR_COUNT-LOG_PRF_BANK_COUNT-1:0] WB_bus_upper_PR_by_bank,
    // issue to the ALU reg-imm pipeline
    output logic                                  issue_valid,
    output logic [3:0]                            issue_op,
    output logic [11:0]                           issue_imm12,
    output logic                                  issue_A_is_zero,
    output logic [LOG_PR_COUNT-1:0]               issue_dest_PR,
    output logic [LOG_ROB_ENTRIES-1:0]            issue_ROB_index,
    output logic                                  issue_A_forward,
    output logic [LOG_PRF_BANK_COUNT-1:0]         issue_A_bank,
    output logic                                  prf_req_A_valid,
    output logic [LOG_PR_COUNT-1:0]               prf_req_A_PR,
    input  logic                                  issue_ready
);

    localparam int N  = ALU_IMM_IQ_ENTRIES;
    localparam int LB = LOG_PRF_BANK_COUNT;
    localparam int CW = $clog2(N + 1);

    // registered entry state
    logic [N-1:0]               valid_reg, valid_next;
    logic [N-1:0]               A_ready_reg, A_ready_next;
    logic [N-1:0]               A_is_zero_reg, A_is_zero_next;
    logic [3:0]                 op_reg [N];
    logic [3:0]                 op_next [N];
    logic [11:0]                imm12_reg [N];
    logic [11:0]                imm12_next [N];
    logic [LOG_PR_COUNT-1:0]    A_PR_reg [N];
    logic [LOG_PR_COUNT-1:0]    A_PR_next [N];
    logic [LOG_PR_COUNT-1:0]    dest_PR_reg [N];
    logic [LOG_PR_COUNT-1:0]    dest_PR_next [N];
    logic [LOG_ROB_ENTRIES-1:0] ROB_index_reg [N];
    logic [LOG_ROB_ENTRIES-1:0] ROB_index_next [N];

    // entry view extended by one all-zero slot above the top, used as shift source
    logic [N:0]                 valid_ext, A_ready_ext, A_is_zero_ext, wake_ext;
    logic [3:0]                 op_ext [N+1];
    logic [11:0]                imm12_ext [N+1];
    logic [LOG_PR_COUNT-1:0]    A_PR_ext [N+1];
    logic [LOG_PR_COUNT-1:0]    dest_PR_ext [N+1];
    logic [LOG_ROB_ENTRIES-1:0] ROB_index_ext [N+1];

    logic [N-1:0]               new_ready;
    logic [N-1:0]               ready;
    logic [N-1:0]               sel_onehot;
    logic [N-1:0]               at_or_above_sel;
    logic                       any_ready;
    logic                       enq_accept;
    logic                       enq_wake;
    logic [LB-1:0]              enq_bank;
    logic [CW-1:0]              valid_count;
    logic [CW-1:0]              enq_slot;

    logic [3:0]                 mux_op;
    logic [11:0]                mux_imm12;
    logic [LOG_PR_COUNT-1:0]    mux_A_PR;
    logic [LOG_PR_COUNT-1:0]    mux_dest_PR;
    logic [LOG_ROB_ENTRIES-1:0] mux_ROB_index;

    // per-entry wakeup, readiness and shift mask
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_entry
            assign new_ready[gi] = WB_bus_valid_by_bank[A_PR_reg[gi][LB-1:0]]
                                 & (WB_bus_upper_PR_by_bank[A_PR_reg[gi][LB-1:0]] == A_PR_reg[gi][LOG_PR_COUNT-1:LB]);
            assign ready[gi] = valid_reg[gi] & (A_ready_reg[gi] | A_is_zero_reg[gi] | new_ready[gi]);
            // entries at or above the selected one move down when it issues
            assign at_or_above_sel[gi] = |sel_onehot[gi:0];

            assign op_ext[gi]        = op_reg[gi];
            assign imm12_ext[gi]     = imm12_reg[gi];
            assign A_PR_ext[gi]      = A_PR_reg[gi];
            assign dest_PR_ext[gi]   = dest_PR_reg[gi];
            assign ROB_index_ext[gi] = ROB_index_reg[gi];
        end
    endgenerate

    assign op_ext[N]        = '0;
    assign imm12_ext[N]     = '0;
    assign A_PR_ext[N]      = '0;
    assign dest_PR_ext[N]   = '0;
    assign ROB_index_ext[N] = '0;
    assign valid_ext        = {1'b0, valid_reg};
    assign A_ready_ext      = {1'b0, A_ready_reg};
    assign A_is_zero_ext    = {1'b0, A_is_zero_reg};
    assign wake_ext         = {1'b0, new_ready};

    // oldest ready entry wins: isolate the lowest set bit
    assign sel_onehot  = ready & (~ready + N'(1));
    assign any_ready   = |ready;
    assign issue_valid = any_ready & issue_ready;

    // space check uses the pre-issue occupancy, so an issue never frees room the same cycle
    assign iq_enq_ready = ~valid_reg[N-1];
    assign enq_accept   = iq_enq_valid & iq_enq_ready;
    assign enq_bank     = iq_enq_A_PR[LB-1:0];
    assign enq_wake     = WB_bus_valid_by_bank[enq_bank]
                        & (WB_bus_upper_PR_by_bank[enq_bank] == iq_enq_A_PR[LOG_PR_COUNT-1:LB]);

    // occupancy count and landing slot for an enqueue after this cycle's collapse
    always_comb begin
        valid_count = '0;
        for (int i = 0; i < N; i++) begin
            valid_count = valid_count + CW'(valid_reg[i]);
        end
        enq_slot = valid_count - CW'(issue_valid);
    end

    // one-hot field mux of the selected entry; all zero when nothing is ready
    always_comb begin
        mux_op        = '0;
        mux_imm12     = '0;
        mux_A_PR      = '0;
        mux_dest_PR   = '0;
        mux_ROB_index = '0;
        for (int i = 0; i < N; i++) begin
            if (sel_onehot[i]) begin
                mux_op        = mux_op        | op_reg[i];
                mux_imm12     = mux_imm12     | imm12_reg[i];
                mux_A_PR      = mux_A_PR      | A_PR_reg[i];
                mux_dest_PR   = mux_dest_PR   | dest_PR_reg[i];
                mux_ROB_index = mux_ROB_index | ROB_index_reg[i];
            end
        end
    end

    assign issue_op        = mux_op;
    assign issue_imm12     = mux_imm12;
    assign issue_dest_PR   = mux_dest_PR;
    assign issue_ROB_index = mux_ROB_index;
    assign issue_A_is_zero = |(sel_onehot & A_is_zero_reg);
    assign issue_A_forward = |(sel_onehot & new_ready & ~A_ready_reg & ~A_is_zero_reg);
    assign issue_A_bank    = mux_A_PR[LB-1:0];
    assign prf_req_A_valid = issue_valid & ~issue_A_is_zero & ~issue_A_forward;
    assign prf_req_A_PR    = mux_A_PR;

    // next entry state: collapse over the issued entry, latch wakeups, then write the enqueue
    always_comb begin
        for (int i = 0; i < N; i++) begin
            if (issue_valid && at_or_above_sel[i]) begin
                valid_next[i]     = valid_ext[i+1];
                A_ready_next[i]   = A_ready_ext[i+1] | (valid_ext[i+1] & wake_ext[i+1]);
                A_is_zero_next[i] = A_is_zero_ext[i+1];
                op_next[i]        = op_ext[i+1];
                imm12_next[i]     = imm12_ext[i+1];
                A_PR_next[i]      = A_PR_ext[i+1];
                dest_PR_next[i]   = dest_PR_ext[i+1];
                ROB_index_next[i] = ROB_index_ext[i+1];
            end else begin
                valid_next[i]     = valid_ext[i];
                A_ready_next[i]   = A_ready_ext[i] | (valid_ext[i] & wake_ext[i]);
                A_is_zero_next[i] = A_is_zero_ext[i];
                op_next[i]        = op_ext[i];
                imm12_next[i]     = imm12_ext[i];
                A_PR_next[i]      = A_PR_ext[i];
                dest_PR_next[i]   = dest_PR_ext[i];
                ROB_index_next[i] = ROB_index_ext[i];
            end
            if (enq_accept && (enq_slot == CW'(i))) begin
                valid_next[i]     = 1'b1;
                A_ready_next[i]   = iq_enq_A_ready | enq_wake;
                A_is_zero_next[i] = iq_enq_A_is_zero;
                op_next[i]        = iq_enq_op;
                imm12_next[i]     = iq_enq_imm12;
                A_PR_next[i]      = iq_enq_A_PR;
                dest_PR_next[i]   = iq_enq_dest_PR;
                ROB_index_next[i] = iq_enq_ROB_index;
            end
        end
    end

    // entry state register with synchronous active-low clear
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            valid_reg     <= '0;
            A_ready_reg   <= '0;
            A_is_zero_reg <= '0;
            for (int i = 0; i < N; i++) begin
                op_reg[i]        <= '0;
                imm12_reg[i]     <= '0;
                A_PR_reg[i]      <= '0;
                dest_PR_reg[i]   <= '0;
                ROB_index_reg[i] <= '0;
            end
        end else begin
            valid_reg     <= valid_next;
            A_ready_reg   <= A_ready_next;
            A_is_zero_reg <= A_is_zero_next;
            op_reg        <= op_next;
            imm12_reg     <= imm12_next;
            A_PR_reg      <= A_PR_next;
            dest_PR_reg   <= dest_PR_next;
            ROB_index_reg <= ROB_index_next;
        end
    end

endmodule

// File: tb/tb_alu_imm_iq.sv
// Testbench for alu_imm_iq: directed scenarios plus random traffic, all checked
// against a queue-based reference model of the issue queue.
module tb_alu_imm_iq;

    localparam int N = 8;

    typedef struct packed {
        logic [3:0]  op;
        logic [11:0] imm;
        logic [6:0]  apr;
        logic        ardy;
        logic        azero;
        logic [6:0]  dest;
        logic [6:0]  rob;
    } ent_t;

    logic            CLK = 1'b0;
    logic            nRST;
    logic            enq_valid;
    logic [3:0]      enq_op;
    logic [11:0]     enq_imm;
    logic [6:0]      enq_apr;
    logic            enq_ardy;
    logic            enq_azero;
    logic [6:0]      enq_dest;
    logic [6:0]      enq_rob;
    logic [3:0]      wb_valid;
    logic [3:0][4:0] wb_upper;
    logic            issue_ready;

    logic            iq_enq_ready;
    logic            issue_valid;
    logic [3:0]      issue_op;
    logic [11:0]     issue_imm12;
    logic            issue_A_is_zero;
    logic [6:0]      issue_dest_PR;
    logic [6:0]      issue_ROB_index;
    logic            issue_A_forward;
    logic [1:0]      issue_A_bank;
    logic            prf_req_A_valid;
    logic [6:0]      prf_req_A_PR;

    logic [43:0]     dut_outs;
    logic [43:0]     exp;
    int              vectors = 0;
    int              miscompares = 0;
    ent_t            q[$];

    alu_imm_iq #(
        .ALU_IMM_IQ_ENTRIES(8), .LOG_PR_COUNT(7), .LOG_ROB_ENTRIES(7),
        .LOG_PRF_BANK_COUNT(2), .PRF_BANK_COUNT(4)
    ) dut (
        .CLK(CLK), .nRST(nRST),
        .iq_enq_valid(enq_valid), .iq_enq_op(enq_op), .iq_enq_imm12(enq_imm),
        .iq_enq_A_PR(enq_apr), .iq_enq_A_ready(enq_ardy), .iq_enq_A_is_zero(enq_azero),
        .iq_enq_dest_PR(enq_dest), .iq_enq_ROB_index(enq_rob), .iq_enq_ready(iq_enq_ready),
        .WB_bus_valid_by_bank(wb_valid), .WB_bus_upper_PR_by_bank(wb_upper),
        .issue_valid(issue_valid), .issue_op(issue_op), .issue_imm12(issue_imm12),
        .issue_A_is_zero(issue_A_is_zero), .issue_dest_PR(issue_dest_PR),
        .issue_ROB_index(issue_ROB_index), .issue_A_forward(issue_A_forward),
        .issue_A_bank(issue_A_bank), .prf_req_A_valid(prf_req_A_valid),
        .prf_req_A_PR(prf_req_A_PR), .issue_ready(issue_ready)
    );

    assign dut_outs = {iq_enq_ready, issue_valid, issue_op, issue_imm12, issue_A_is_zero,
                       issue_dest_PR, issue_ROB_index, issue_A_forward, issue_A_bank,
                       prf_req_A_valid, prf_req_A_PR};

    always #5 CLK = ~CLK;

    // ---------------- reference model ----------------
    function automatic bit woke(logic [6:0] pr);
        return wb_valid[pr[1:0]] && (wb_upper[pr[1:0]] == pr[6:2]);
    endfunction

    function automatic int find_sel();
        foreach (q[i]) if (q[i].ardy || q[i].azero || woke(q[i].apr)) return i;
        return -1;
    endfunction

    function automatic logic [43:0] exp_outs();
        int   s;
        ent_t e;
        logic er, iv, fwd, pv;
        s  = find_sel();
        er = (q.size() < N);
        if (s < 0) return {er, 43'b0};
        e   = q[s];
        iv  = issue_ready;
        fwd = woke(e.apr) && !e.ardy && !e.azero;
        pv  = iv && !e.azero && !fwd;
        return {er, iv, e.op, e.imm, e.azero, e.dest, e.rob, fwd, e.apr[1:0], pv, e.apr};
    endfunction

    // apply one clock edge to the model using the inputs currently driven
    task automatic advance();
        ent_t nq[$];
        ent_t e;
        int   s;
        nq = q;
        s  = find_sel();
        if (s >= 0 && issue_ready) nq.delete(s);
        foreach (nq[i]) if (woke(nq[i].apr)) nq[i].ardy = 1'b1;
        if (enq_valid && q.size() < N) begin
            e.op = enq_op; e.imm = enq_imm; e.apr = enq_apr; e.azero = enq_azero;
            e.dest = enq_dest; e.rob = enq_rob; e.ardy = enq_ardy | woke(enq_apr);
            nq.push_back(e);
        end
        if (!nRST) nq.delete();
        @(posedge CLK);
        q = nq;
        @(negedge CLK);
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        enq_valid = 0; enq_op = 0; enq_imm = 0; enq_apr = 0; enq_ardy = 0;
        enq_azero = 0; enq_dest = 0; enq_rob = 0; wb_valid = 0; wb_upper = '0;
    endtask

    task automatic set_enq(input logic [3:0] op, input logic [11:0] imm, input logic [6:0] apr,
                           input logic ardy, input logic azero, input logic [6:0] dest,
                           input logic [6:0] rob);
        enq_valid = 1; enq_op = op; enq_imm = imm; enq_apr = apr; enq_ardy = ardy;
        enq_azero = azero; enq_dest = dest; enq_rob = rob;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        nRST = 0; idle(); issue_ready = 1;
        advance();
        nRST = 1;
        #1;
        vectors++;
        if (dut_outs !== {1'b1, 43'b0}) begin
            miscompares++;
            $display("FAIL reset_outs got=%h want=%h", dut_outs, {1'b1, 43'b0});
        end
        exp = exp_outs();
        vectors++;
        if (dut_outs !== exp) begin
            miscompares++;
            $display("FAIL reset_model got=%h want=%h", dut_outs, exp);
        end
    endtask

    task automatic test_basic();
        set_enq(4'h3, 12'h7FF, 7'd20, 1, 0, 7'd9, 7'd5);
        #1; exp = exp_outs(); vectors++;
        if (dut_outs !== exp || issue_valid !== 1'b0) begin
            miscompares++; $display("FAIL basic_enq got=%h want=%h", dut_outs, exp);
        end
        advance();
        idle();
        #1; exp = exp_outs(); vectors++;
        if (dut_outs !== exp) begin
            miscompares++; $display("FAIL basic_issue got=%h want=%h", dut_outs, exp);
        end
        vectors++;
        if (issue_valid !== 1'b1 || prf_req_A_PR !== 7'd20 || issue_A_forward !== 1'b0
            || issue_dest_PR !== 7'd9 || issue_op !== 4'h3 || issue_imm12 !== 12'h7FF) begin
            miscompares++;
            $display("FAIL basic_fields got v=%b pr=%0d fwd=%b dest=%0d op=%h imm=%h want v=1 pr=20 fwd=0 dest=9 op=3 imm=7ff",
                     issue_valid, prf_req_A_PR, issue_A_forward, issue_dest_PR, issue_op, issue_imm12);
        end
        advance();
    endtask

    task automatic test_forward();
        idle();
        set_enq(4'h1, 12'h111, 7'd12, 0, 0, 7'd21, 7'd1);
        #1; exp = exp_outs(); vectors++;
        if (dut_outs !== exp) begin miscompares++; $display("FAIL fwd_enqA got=%h want=%h", dut_outs, exp); end
        advance();
        set_enq(4'h2, 12'h222, 7'd40, 1, 0, 7'd22, 7'd2);
        #1; exp = exp_outs(); vectors++;
        if (dut_outs !== exp) begin miscompares++; $display("FAIL fwd_enqB got=%h want=%h", dut_outs, exp); end
        advance();
        idle();
        #1; exp = exp_outs(); vectors++;
        if (dut_outs !== exp || issue_dest_PR !== 7'd22 || issue_valid !== 1'b1) begin
            miscompares++; $display("FAIL fwd_B_first got=%h want=%h", dut_outs, exp);
        end
        advance();
        wb_valid = 4'b0001; wb_upper[0] = 5'd3;
        #1; exp = exp_outs(); vectors++;
        if (dut_outs !== exp) begin miscompares++; $display("FAIL fwd_wake got=%h want=%h", dut_outs, exp); end
        vectors++;
        if (issue_valid !== 1'b1 || issue_dest_PR !== 7'd21 || issue_A_forward !== 1'b1 || prf_req_A_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL fwd_A_fields got v=%b dest=%0d fwd=%b prf=%b want v=1 dest=21 fwd=1 prf=0",
                     issue_valid, issue_dest_PR, issue_A_forward, prf_req_A_valid);
        end
        advance();
        idle();
    endtask

    task automatic test_full_wake();
        idle();
        for (int i = 0; i < N; i++) begin
            set_enq(4'(i), 12'(i * 3), 7'(32 + i), 0, 0, 7'(40 + i), 7'(i));
            #1; exp = exp_outs(); vectors++;
            if (dut_outs !== exp) begin miscompares++; $display("FAIL full_fill%0d got=%h want=%h", i, dut_outs, exp); end
            advance();
        end
        set_enq(4'hF, 12'hFFF, 7'd1, 1, 0, 7'd99, 7'd99);
        #1; exp = exp_outs(); vectors++;
        if (dut_outs !== exp || iq_enq_ready !== 1'b0 || issue_valid !== 1'b0) begin
            miscompares++; $display("FAIL full_blocked got=%h want=%h", dut_outs, exp);
        end
        advance();
        idle(); wb_valid = 4'b0010; wb_upper[1] = 5'd9;
        #1; exp = exp_outs(); vectors++;
        if (dut_outs !== exp || issue_dest_PR !== 7'd45 || issue_A_forward !== 1'b1) begin
            miscompares++; $display("FAIL full_wake5 got=%h want=%h", dut_outs, exp);
        end
        advance();
        idle();
        #1; exp = exp_outs(); vectors++;
        if (dut_outs !== exp || iq_enq_ready !== 1'b1 || issue_valid !== 1'b0) begin
            miscompares++; $display("FAIL full_space got=%h want=%h", dut_outs, exp);
        end
        advance();
        wb_valid = 4'b0100; wb_upper[2] = 5'd9;
        #1; exp = exp_outs(); vectors++;
        if (dut_outs !== exp || issue_dest_PR !== 7'd46) begin
            miscompares++; $display("FAIL full_shift got=%h want=%h", dut_outs, exp);
        end
        advance();
        idle(); nRST = 0;
        advance();
        nRST = 1;
    endtask

    task automatic test_issue_enq();
        idle(); issue_ready = 0;
        for (int i = 0; i < 3; i++) begin
            if (i == 0) set_enq(4'h4, 12'h004, 7'd50, 1, 0, 7'd10, 7'd10);
            if (i == 1) set_enq(4'h5, 12'h005, 7'd61, 0, 0, 7'd11, 7'd11);
            if (i == 2) set_enq(4'h6, 12'h006, 7'd66, 0, 0, 7'd12, 7'd12);
            #1; exp = exp_outs(); vectors++;
            if (dut_outs !== exp) begin miscompares++; $display("FAIL ie_fill%0d got=%h want=%h", i, dut_outs, exp); end
            advance();
        end
        issue_ready = 1;
        set_enq(4'h7, 12'h007, 7'd71, 0, 0, 7'd13, 7'd13);
        #1; exp = exp_outs(); vectors++;
        if (dut_outs !== exp || issue_valid !== 1'b1 || issue_dest_PR !== 7'd10) begin
            miscompares++; $display("FAIL ie_both got=%h want=%h", dut_outs, exp);
        end
        advance();
        idle(); wb_valid = 4'b1110; wb_upper[1] = 5'd15; wb_upper[2] = 5'd16; wb_upper[3] = 5'd17;
        for (int i = 0; i < 3; i++) begin
            #1; exp = exp_outs(); vectors++;
            if (dut_outs !== exp || issue_dest_PR !== 7'(11 + i) || issue_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL ie_order%0d got dest=%0d outs=%h want dest=%0d outs=%h", i, issue_dest_PR, dut_outs, 11 + i, exp);
            end
            advance();
            idle();
        end
    endtask

    task automatic test_zero();
        idle();
        set_enq(4'h5, 12'h800, 7'd0, 0, 1, 7'd30, 7'd3);
        #1; exp = exp_outs(); vectors++;
        if (dut_outs !== exp || issue_valid !== 1'b0) begin
            miscompares++; $display("FAIL zero_enq got=%h want=%h", dut_outs, exp);
        end
        advance();
        idle();
        #1; exp = exp_outs(); vectors++;
        if (dut_outs !== exp || issue_valid !== 1'b1 || prf_req_A_valid !== 1'b0 || issue_A_forward !== 1'b0) begin
            miscompares++; $display("FAIL zero_issue got=%h want=%h", dut_outs, exp);
        end
        advance();
    endtask

    task automatic test_stall_reset();
        idle(); issue_ready = 0;
        for (int i = 0; i < 2; i++) begin
            set_enq(4'h9, 12'(i), 7'(80 + i), 1, 0, 7'(50 + i), 7'(i));
            #1; exp = exp_outs(); vectors++;
            if (dut_outs !== exp) begin miscompares++; $display("FAIL stall_fill%0d got=%h want=%h", i, dut_outs, exp); end
            advance();
        end
        idle();
        for (int c = 0; c < 3; c++) begin
            #1; exp = exp_outs(); vectors++;
            if (dut_outs !== exp || issue_valid !== 1'b0 || prf_req_A_valid !== 1'b0) begin
                miscompares++; $display("FAIL stall_hold%0d got=%h want=%h", c, dut_outs, exp);
            end
            advance();
        end
        issue_ready = 1;
        #1; exp = exp_outs(); vectors++;
        if (dut_outs !== exp || issue_valid !== 1'b1 || issue_dest_PR !== 7'd50) begin
            miscompares++; $display("FAIL stall_release got=%h want=%h", dut_outs, exp);
        end
        advance();
        nRST = 0;
        set_enq(4'h1, 12'h1, 7'd3, 1, 0, 7'd60, 7'd6);
        #1; exp = exp_outs(); vectors++;
        if (dut_outs !== exp || issue_dest_PR !== 7'd51) begin
            miscompares++; $display("FAIL stall_prereset got=%h want=%h", dut_outs, exp);
        end
        advance();
        nRST = 1; idle();
        #1; vectors++;
        if (dut_outs !== {1'b1, 43'b0}) begin
            miscompares++; $display("FAIL stall_postreset got=%h want=%h", dut_outs, {1'b1, 43'b0});
        end
        advance();
    endtask

    task automatic test_random();
        int t;
        for (int c = 0; c < 600; c++) begin
            nRST        = ($urandom_range(0, 63) != 0);
            issue_ready = ($urandom_range(0, 3) != 0);
            enq_valid   = ($urandom_range(0, 9) < 6);
            enq_op      = 4'($urandom);
            enq_imm     = 12'($urandom);
            enq_apr     = 7'($urandom);
            enq_ardy    = ($urandom_range(0, 9) < 3);
            enq_azero   = ($urandom_range(0, 9) == 0);
            enq_dest    = 7'($urandom);
            enq_rob     = 7'($urandom);
            for (int b = 0; b < 4; b++) begin
                wb_valid[b] = ($urandom_range(0, 3) == 0);
                wb_upper[b] = 5'($urandom);
            end
            if (q.size() > 0 && $urandom_range(0, 9) < 4) begin
                t = $urandom_range(0, q.size() - 1);
                wb_valid[q[t].apr[1:0]] = 1'b1;
                wb_upper[q[t].apr[1:0]] = q[t].apr[6:2];
            end
            #1; exp = exp_outs(); vectors++;
            if (dut_outs !== exp) begin
                miscompares++; $display("FAIL random_c%0d got=%h want=%h", c, dut_outs, exp);
            end
            advance();
        end
        nRST = 1; idle();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_forward();
        test_full_wake();
        test_issue_enq();
        test_zero();
        test_stall_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
